// File: rtl/cba_pkg.sv
// Shared types and defaults for the carry-bypass stream accumulator.
package cba_pkg;

  typedef enum logic [0:0] {ACC, HOLD} cba_acc_state_t;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/carry_bypass_adder.sv
// Carry-bypass adder: ripple blocks of BLK bits whose carry-in skips the block
// when every bit in it propagates.
module carry_bypass_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] s;
  logic             c;
  logic             blk_cin;
  logic             p_blk;

  always_comb begin
    s       = '0;
    c       = cin;
    blk_cin = cin;
    p_blk   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      p_blk = p_blk & (a[i] ^ b[i]);
      // Block boundary: a fully propagating block forwards its own carry-in.
      if (((i % BLK) == (BLK - 1)) || (i == (WIDTH - 1))) begin
        if (p_blk) c = blk_cin;
        blk_cin = c;
        p_blk   = 1'b1;
      end
    end
  end

  assign sum  = s;
  assign cout = c;

endmodule

// File: rtl/cba_stream_accumulator.sv
// Packet accumulator behind a valid/ready stream; all addition goes through one
// carry_bypass_adder. Define CBA_ACC_SATURATE_EN to clamp the total at all-ones.
module cba_stream_accumulator
  import cba_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

`ifdef CBA_ACC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  cba_acc_state_t   state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_carry_q, out_carry_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  carry_bypass_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  function automatic logic [WIDTH-1:0] sat_acc(input logic [WIDTH-1:0] sum,
                                               input logic cout,
                                               input logic sticky);
    return (SAT_EN && (cout || sticky)) ? '1 : sum;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    out_count_d = out_count_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d   = sat_acc(add_sum, add_cout, carry_q);
          carry_d = carry_q | add_cout;
          count_d = sat_inc(count_q);
          if (in_last) begin
            out_sum_d   = acc_d;
            out_carry_d = carry_d;
            out_count_d = count_d;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        // Result registers stay put; only the running totals clear.
        if (out_ready) begin
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_cba_stream_accumulator.sv
// Directed bench for cba_stream_accumulator (default build and CBA_ACC_SATURATE_EN).
module tb_cba_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [15:0] in_data;
  logic        in_ready, out_valid, out_carry;
  logic [15:0] out_sum;
  logic [7:0]  out_count;

  logic        in2_valid, in2_last, out2_ready;
  logic [15:0] in2_data;
  logic        in2_ready, out2_valid, out2_carry;
  logic [15:0] out2_sum;
  logic [1:0]  out2_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cba_stream_accumulator #(.WIDTH(16), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_count(out_count)
  );

  cba_stream_accumulator #(.WIDTH(16), .CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_data(in2_data), .in_last(in2_last),
    .out_valid(out2_valid), .out_ready(out2_ready),
    .out_sum(out2_sum), .out_carry(out2_carry), .out_count(out2_count)
  );

`ifdef CBA_ACC_SATURATE_EN
  localparam logic [15:0] OVF_SUM = 16'hFFFF;
`else
  localparam logic [15:0] OVF_SUM = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [15:0] sum,
                         input logic carry, input logic [7:0] cnt);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_sum"},   out_sum,   sum);
    chk({tag, "_carry"}, out_carry, carry);
    chk({tag, "_count"}, out_count, cnt);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready,  1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_last = 1'b0; in2_data = '0; out2_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum",   out_sum,   16'h0);
    chk("rst_out_carry", out_carry, 1'b0);
    chk("rst_out_count", out_count, 8'h0);
    chk("rst_in_ready",  in_ready,  1'b1);

    // Two-beat packet and 1-cycle latency
    send(16'h1234, 1'b0);
    chk("t1_no_valid_early", out_valid, 1'b0);
    send(16'h5678, 1'b1);
    chk("t1_in_ready_hold", in_ready, 1'b0);
    collect("t1", 16'h68AC, 1'b0, 8'd2);

    // Overflow on the second beat
    send(16'hFFFF, 1'b0);
    send(16'h0001, 1'b1);
    collect("t2", OVF_SUM, 1'b1, 8'd2);

    // Sticky carry, then cleared on the next packet
    send(16'hAAAA, 1'b0);
    send(16'h5555, 1'b0);
    send(16'h0001, 1'b1);
    collect("t3", OVF_SUM, 1'b1, 8'd3);
    send(16'h0F0F, 1'b1);
    collect("t3b", 16'h0F0F, 1'b0, 8'd1);

    // Backpressure: beats offered in HOLD are ignored
    send(16'h0100, 1'b0);
    send(16'h0023, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h1111;
      in_last  = (i == 4);
      @(posedge clk);
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_sum",      out_sum,  16'h0123);
      chk("bp_valid",    out_valid, 1'b1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    collect("bp", 16'h0123, 1'b0, 8'd2);
    send(16'h0002, 1'b1);
    collect("bp_next", 16'h0002, 1'b0, 8'd1);

    // Reset mid-packet
    send(16'h1000, 1'b0);
    send(16'h2000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid",    out_valid, 1'b0);
    chk("mrst_sum",      out_sum,   16'h0);
    chk("mrst_carry",    out_carry, 1'b0);
    chk("mrst_count",    out_count, 8'h0);
    chk("mrst_in_ready", in_ready,  1'b1);
    send(16'h7FFF, 1'b0);
    send(16'h8001, 1'b1);
    collect("mrst_pkt", OVF_SUM, 1'b1, 8'd2);

    // Counter saturation with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in2_valid = 1'b1;
      in2_data  = 16'h0001;
      in2_last  = (i == 4);
      @(posedge clk);
      #1;
    end
    in2_valid = 1'b0;
    in2_last  = 1'b0;
    chk("c2_valid", out2_valid, 1'b1);
    chk("c2_count", out2_count, 2'd3);
    chk("c2_sum",   out2_sum,   16'h0005);
    chk("c2_carry", out2_carry, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
